seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
Time-multiplexed scan controller that feeds the team's 4-digit seven-segment decoder. It holds a 16-bit shadow copy of four BCD/hex digits and steps a digit-select index through slots 0..3 at a fixed refresh rate, presenting one nibble per slot. It supports per-digit blanking and blinking, used for alarm-set mode. New digit values are taken from the time/alarm logic through a request/acknowledge handshake. Capture happens only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (>=2)
BLINK_DIV, 50000000, clock cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
digits  input  16  candidate digits; [3:0]=slot 0 … [15:12]=slot 3
upd_req  input  1  requester holds high until upd_ack
upd_ack  output  1  one-cycle pulse: digits captured into shadow
blank_mask  input  4  bit i=1 forces slot i dark
blink_mask  input  4  bit i=1 blinks slot i
en  output  2  current slot index, drives decoder en
num  output  4  nibble for current slot, drives decoder num
blank  output  1  1 = current slot dark (anodes gated off downstream)
frame_start  output  1  one-cycle pulse when en enters slot 0

Behaviour:
- Reset (rst_n low at clk edge): scan counter=0, blink counter=0, blink_phase=0, en=0, shadow=0, num=0, valid=0, blank=1, upd_ack=0, frame_start=0. Any pending request is dropped. Reset mid-frame behaves the same.
- Scan counter counts 0..SCAN_DIV-1 and wraps. tick = (count==SCAN_DIV-1).
- On tick, the next edge sets en <= en+1, wrapping 3->0. num and blank are registered on that same edge from the new en, so en/num/blank always describe the same slot. Each slot lasts exactly SCAN_DIV cycles.
- Frame boundary = tick while en==3.
- At a frame boundary with upd_req=1, on that edge:
  - shadow <= digits
  - valid <= 1
  - upd_ack <= 1 for exactly one cycle
  - slot 0's num comes from the newly captured digits.
- upd_req is sampled only at boundaries. If upd_req stays high after the ack, capture and ack repeat at every boundary. The requester must hold digits stable while upd_req=1.
- frame_start=1 for the single cycle after en wraps to 0, coincident with any upd_ack.
- Blink counter counts 0..BLINK_DIV-1 and toggles blink_phase on wrap. It is free-running and independent of the scan counter.
- Registered blank = !valid | blank_mask[slot] | (blink_mask[slot] & blink_phase). blank_mask has priority, and blink has no visible effect on a masked slot.
- Mask inputs are sampled at each slot entry. A mask change becomes visible at the next slot entry, not mid-slot.
- When blank=1, num still carries the shadow nibble; it is not forced to 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: slot 3 is additionally blanked when shadow[15:12]==0. Slot 2 is additionally blanked when shadow[15:8]==0. Slots 1 and 0 are never suppressed. This ORs into the blank equation.
- Undefined: no zero suppression, and no extra logic is compiled.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> en=0, num=0, blank=1, upd_ack=0, frame_start=0. Held through release, then the scan starts at count 0.
- Scan order: SCAN_DIV=4, no requests -> en 0,1,2,3,0 changing every 4 cycles, blank=1 throughout (valid=0), frame_start pulses every 16 cycles.
- Update handshake: SCAN_DIV=4, digits=16'h1234, upd_req raised while en=1 -> no ack until the slot-3 tick. upd_ack is a single pulse with frame_start. Then slots 0..3 show num=4,3,2,1 with blank=0. Drop upd_req after the ack -> no further ack.
- Held request: upd_req held high, digits changed 16'h1234->16'h5678 mid-frame -> ack at every boundary. The new value appears only from the next slot 0, and the frame never mixes 1234/5678 nibbles.
- Blink/blank: BLINK_DIV=16, blink_mask=4'b0100 -> slot 2 blank toggles with the 16-cycle phase while other slots stay lit. Adding blank_mask=4'b0100 -> slot 2 is permanently dark.
- Reset mid-operation, plus macro check: assert rst_n=0 at en=2 with upd_req=1 -> no ack, outputs return to reset values. With LEADING_ZERO_BLANK_EN and digits=16'h0059 -> slots 3 and 2 are dark, slots 1 and 0 show 5 and 9. With 16'h0109 -> only slot 3 is dark.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Digit-update handshake between the time/alarm logic (master) and the
// seven-segment scan driver (slave).
interface seg_scan_driver_if;
    logic [15:0] digits;
    logic        upd_req;
    logic        upd_ack;

    modport master (output digits, output upd_req, input upd_ack);
    modport slave  (input digits, input upd_req, output upd_ack);
endinterface

// File: rtl/seg_scan_driver.sv
// Four-slot seven-segment scan driver with frame-aligned digit capture,
// per-slot blank/blink; LEADING_ZERO_BLANK_EN adds leading-zero suppression.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave upd,
    input  logic [3:0]       blank_mask,
    input  logic [3:0]       blink_mask,
    output logic [1:0]       en,
    output logic [3:0]       num,
    output logic             blank,
    output logic             frame_start
);
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [15:0]   shadow;
    logic          valid;

    logic          tick, boundary, capture, valid_nxt, blank_nxt;
    logic [1:0]    en_nxt;
    logic [15:0]   shadow_nxt;
    logic [3:0]    num_nxt;

    // Everything registered on a tick is computed from the slot being entered,
    // so en/num/blank always move together.
    always_comb begin
        tick       = (scan_cnt == SCAN_LAST);
        en_nxt     = en + 2'd1;
        boundary   = tick && (en == 2'd3);
        capture    = boundary && upd.upd_req;
        shadow_nxt = capture ? upd.digits : shadow;
        valid_nxt  = valid | capture;
        case (en_nxt)
            2'd0:    num_nxt = shadow_nxt[3:0];
            2'd1:    num_nxt = shadow_nxt[7:4];
            2'd2:    num_nxt = shadow_nxt[11:8];
            default: num_nxt = shadow_nxt[15:12];
        endcase
        blank_nxt = !valid_nxt | blank_mask[en_nxt] | (blink_mask[en_nxt] & blink_phase);
`ifdef LEADING_ZERO_BLANK_EN
        blank_nxt = blank_nxt
                  | ((en_nxt == 2'd3) && (shadow_nxt[15:12] == 4'd0))
                  | ((en_nxt == 2'd2) && (shadow_nxt[15:8]  == 8'd0));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            en          <= 2'd0;
            shadow      <= 16'd0;
            valid       <= 1'b0;
            num         <= 4'd0;
            blank       <= 1'b1;
            upd.upd_ack <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            upd.upd_ack <= capture;
            frame_start <= boundary;
            if (tick) begin
                en     <= en_nxt;
                shadow <= shadow_nxt;
                valid  <= valid_nxt;
                num    <= num_nxt;
                blank  <= blank_nxt;
            end
        end
    end
endmodule
